// File: rtl/ce_pkg.sv
// ce_pkg: shared width and sequencing helpers for the channel-fold compute engine.
//   clog2     : ceiling log2 of a positive integer (0 for v <= 1).
//   beats     : input beats per output group, ceil(cl_in / lanes).
//   acc_width : accumulator width that holds a full group without overflow.
//   cnt_width : beat counter width (at least one bit).
//   beat_tag_t: per-beat sideband carried alongside the datapath pipeline.
package ce_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int beats(input int cl_in, input int lanes);
    return (cl_in + lanes - 1) / lanes;
  endfunction

  // Product width plus enough growth bits for every product of the group,
  // plus one more so the signed bias can be folded in.
  function automatic int acc_width(input int n, input int m, input int cl_in, input int kernel);
    return n + m + clog2(cl_in * kernel * kernel) + 1;
  endfunction

  function automatic int cnt_width(input int num_beats);
    return (num_beats > 1) ? clog2(num_beats) : 1;
  endfunction

  typedef struct packed {
    logic valid;  // stage holds an accepted beat, not a bubble
    logic first;  // beat 0 of its group: accumulator is reloaded with bias
    logic last;   // final beat of its group: result goes to the output register
  } beat_tag_t;

endpackage

// File: rtl/ce_mac_tree.sv
// ce_mac_tree: multiplies every data/weight element of one beat and sums them.
//   clk  : clock
//   en   : pipeline advance; both stages hold when low
//   data : LANES*K*K signed N-bit elements, packed element 0 at the LSBs
//   w    : LANES*K*K signed M-bit weights, same packing as data
//   sum  : signed ACCW-bit beat sum, two register stages after the inputs
// Stage S1 registers the products, stage S2 registers the adder-tree sum.
module ce_mac_tree
  import ce_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int KERNEL = 3,
  parameter int N      = 4,
  parameter int M      = 4,
  parameter int ACCW   = N + M + clog2(LANES * KERNEL * KERNEL) + 1
) (
  input  logic                             clk,
  input  logic                             en,
  input  logic [LANES*KERNEL*KERNEL*N-1:0] data,
  input  logic [LANES*KERNEL*KERNEL*M-1:0] w,
  output logic [ACCW-1:0]                  sum
);

  localparam int TERMS = LANES * KERNEL * KERNEL;
  localparam int PW    = N + M;

  logic signed [PW-1:0]   prod_c [TERMS];
  logic signed [PW-1:0]   prod_q [TERMS];
  logic signed [ACCW-1:0] tree_c;

  // Both operands are sign-extended to the full product width before the
  // multiply so the product is exact for every signed input pair.
  always_comb begin
    for (int i = 0; i < TERMS; i++) begin
      prod_c[i] = PW'($signed(data[i*N +: N])) * PW'($signed(w[i*M +: M]));
    end
  end

  // NOTE: pure datapath registers carry no reset; the tag bits that travel
  // with them in the parent are reset, so stale values here are never used.
  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < TERMS; i++) begin
        prod_q[i] <= prod_c[i];
      end
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    tree_c = '0;
    for (int i = 0; i < TERMS; i++) begin
      tree_c = tree_c + ACCW'(prod_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (en) sum <= tree_c;
  end

endmodule

// File: rtl/ce_fold.sv
// ce_fold: folds CL_IN channel windows into one convolution output pixel,
// LANES channels per accepted beat, BEATS beats per output.
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   in_valid  : a beat is offered on data/w/bias
//   in_ready  : beat accepted when in_valid && in_ready
//   data      : LANES windows of K*K signed N-bit values
//   w         : LANES windows of K*K signed M-bit weights
//   bias      : signed N+M bias, used on the first beat of a group
//   out_valid : d_out holds a result
//   out_ready : result consumed when out_valid && out_ready
//   d_out     : signed OW-bit result (shift, optional ReLU, saturate)
// Pipeline: S1 products, S2 beat sum (both in ce_mac_tree), S3 accumulate and
// output register. The whole pipeline stalls only while a result waits.
module ce_fold
  import ce_pkg::*;
#(
  parameter int CL_IN  = 14,
  parameter int KERNEL = 3,
  parameter int LANES  = 4,
  parameter int N      = 4,
  parameter int M      = 4,
  parameter int SR     = 2,
  parameter int RELU   = 1,
  parameter int OW     = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANES*KERNEL*KERNEL*N-1:0] data,
  input  logic [LANES*KERNEL*KERNEL*M-1:0] w,
  input  logic [N+M-1:0]                   bias,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [OW-1:0]                    d_out
);

  localparam int KK    = KERNEL * KERNEL;
  localparam int LW_N  = KK * N;
  localparam int LW_M  = KK * M;
  localparam int BEATS = beats(CL_IN, LANES);
  localparam int ACCW  = acc_width(N, M, CL_IN, KERNEL);
  localparam int CW    = cnt_width(BEATS);
  // Post-processing width: wide enough for both the accumulator and the
  // output range, with a spare bit so the clamp comparisons never wrap.
  localparam int XW    = ((ACCW > OW) ? ACCW : OW) + 1;

  localparam logic signed [XW-1:0] SAT_MAX = {{(XW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [XW-1:0] SAT_MIN = {{(XW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  logic                        en;
  logic                        accept;
  logic [CW-1:0]               beat_cnt;
  logic                        last_beat;
  logic [LANES-1:0]            lane_on;
  logic [LANES*LW_N-1:0]       data_m;
  logic [LANES*LW_M-1:0]       w_m;
  logic signed [ACCW-1:0]      beat_sum;
  logic signed [ACCW-1:0]      acc;
  logic signed [ACCW-1:0]      acc_next;
  beat_tag_t                   s1_tag;
  beat_tag_t                   s2_tag;
  logic [N+M-1:0]              s1_bias;
  logic [N+M-1:0]              s2_bias;

  // A waiting, unconsumed result freezes every stage; otherwise all advance.
  assign en        = !(out_valid && !out_ready);
  assign in_ready  = en;
  assign accept    = in_valid && en;
  assign last_beat = (beat_cnt == CW'(BEATS - 1));

  // Lanes past the last real channel only exist on the final beat; they are
  // zeroed at the input so whatever the source drives there cannot leak in.
  always_comb begin
    lane_on = '0;
    data_m  = '0;
    w_m     = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_on[l] = (int'(beat_cnt) * LANES + l) < CL_IN;
      if (lane_on[l]) begin
        data_m[l*LW_N +: LW_N] = data[l*LW_N +: LW_N];
        w_m[l*LW_M +: LW_M]    = w[l*LW_M +: LW_M];
      end
    end
  end

  ce_mac_tree #(
    .LANES  (LANES),
    .KERNEL (KERNEL),
    .N      (N),
    .M      (M),
    .ACCW   (ACCW)
  ) u_mac_tree (
    .clk  (clk),
    .en   (en),
    .data (data_m),
    .w    (w_m),
    .sum  (beat_sum)
  );

  // Beat counter and the tags that follow each beat through S1/S2. A bubble
  // enters as an invalid tag, so it never moves the counter or the accumulator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt <= '0;
      s1_tag   <= '0;
      s2_tag   <= '0;
    end else if (en) begin
      s1_tag <= '{valid: accept,
                  first: accept && (beat_cnt == '0),
                  last:  accept && last_beat};
      s2_tag <= s1_tag;
      if (accept) begin
        beat_cnt <= last_beat ? '0 : beat_cnt + CW'(1);
      end
    end
  end

  // Bias rides along with its beat; only the copy tagged first is consumed.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_bias <= bias;
      s2_bias <= s1_bias;
    end
  end

  always_comb begin
    acc_next = acc + beat_sum;
    if (s2_tag.first) acc_next = ACCW'($signed(s2_bias)) + beat_sum;
  end

  // Floor shift, optional ReLU, then clamp to the signed OW range.
  function automatic logic [OW-1:0] post_proc(input logic signed [ACCW-1:0] v);
    logic signed [XW-1:0] x;
    x = XW'(v >>> SR);
    if ((RELU != 0) && (x < 0)) x = '0;
    if (x > SAT_MAX)      x = SAT_MAX;
    else if (x < SAT_MIN) x = SAT_MIN;
    return x[OW-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (en && s2_tag.valid) begin
      acc <= acc_next;
    end
  end

  // When en is high and a result is showing, out_ready must be high, so the
  // old result is consumed this cycle; a new final beat simply replaces it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      d_out     <= '0;
    end else if (en) begin
      if (s2_tag.valid && s2_tag.last) begin
        out_valid <= 1'b1;
        d_out     <= post_proc(acc_next);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ce_fold.sv
// tb_ce_fold: table-driven and randomized checks of ce_fold at default
// parameters, with a RELU=0 twin sharing the same stimulus.
module tb_ce_fold;

  localparam int CL_IN  = 14;
  localparam int KERNEL = 3;
  localparam int LANES  = 4;
  localparam int N      = 4;
  localparam int M      = 4;
  localparam int SR     = 2;
  localparam int OW     = 8;
  localparam int KK     = KERNEL * KERNEL;
  localparam int BW     = N + M;
  localparam int BEATS  = (CL_IN + LANES - 1) / LANES;

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_ready_nr;
  logic [LANES*KK*N-1:0] data;
  logic [LANES*KK*M-1:0] w;
  logic [BW-1:0]         bias;
  logic                  out_valid;
  logic                  out_valid_nr;
  logic                  out_ready;
  logic [OW-1:0]         d_out;
  logic [OW-1:0]         d_out_nr;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit sb_watch = 0;

  int got_q[$];
  int got_cyc_q[$];
  int exp_q[$];

  int            m_beat;
  int            m_acc;
  bit            prev_stall;
  logic [OW-1:0] prev_d;

  typedef struct {
    int dv;
    int wv;
    int bv;
    bit hi7;
    int exp_relu;
    int exp_pass;
  } vec_t;

  vec_t tbl[10];

  ce_fold #(
    .CL_IN(CL_IN), .KERNEL(KERNEL), .LANES(LANES), .N(N), .M(M),
    .SR(SR), .RELU(1), .OW(OW)
  ) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data(data), .w(w), .bias(bias), .out_valid(out_valid),
    .out_ready(out_ready), .d_out(d_out)
  );

  ce_fold #(
    .CL_IN(CL_IN), .KERNEL(KERNEL), .LANES(LANES), .N(N), .M(M),
    .SR(SR), .RELU(0), .OW(OW)
  ) u_dut_nr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_nr),
    .data(data), .w(w), .bias(bias), .out_valid(out_valid_nr),
    .out_ready(out_ready), .d_out(d_out_nr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference post-processing: floor divide by 2^SR, clamp negatives (RELU=1),
  // saturate into the signed 8-bit range.
  function automatic int ref_post(input int s);
    int v;
    v = s >>> SR;
    if (v < 0) v = 0;
    if (v > 127) v = 127;
    return v;
  endfunction

  // Reference model and monitor. Values are sampled at the falling edge, where
  // they equal what the DUT sees at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      m_beat     = 0;
      prev_stall = 0;
    end else begin
      if (sb_watch) begin
        check("in_ready_rule", int'(in_ready), (out_valid && !out_ready) ? 0 : 1);
        if (prev_stall) begin
          check("stall_valid", int'(out_valid), 1);
          check("stall_hold", int'(d_out), int'(prev_d));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_d     = d_out;
      if (out_valid && out_ready) begin
        got_q.push_back(int'($signed(d_out)));
        got_cyc_q.push_back(cyc);
      end
      if (in_valid && in_ready) begin
        if (m_beat == 0) m_acc = int'($signed(bias));
        for (int l = 0; l < LANES; l++) begin
          if (m_beat * LANES + l < CL_IN) begin
            for (int k = 0; k < KK; k++) begin
              m_acc += int'($signed(data[(l*KK+k)*N +: N])) *
                       int'($signed(w[(l*KK+k)*M +: M]));
            end
          end
        end
        m_beat++;
        if (m_beat == BEATS) begin
          exp_q.push_back(ref_post(m_acc));
          m_beat = 0;
        end
      end
    end
  end

  task automatic set_beat(input int dv, input int wv, input int bv, input bit hi7, input int b);
    for (int l = 0; l < LANES; l++) begin
      for (int k = 0; k < KK; k++) begin
        if (hi7 && b == BEATS - 1 && l >= 2) begin
          data[(l*KK+k)*N +: N] = N'(7);
          w[(l*KK+k)*M +: M]    = M'(7);
        end else begin
          data[(l*KK+k)*N +: N] = N'(dv);
          w[(l*KK+k)*M +: M]    = M'(wv);
        end
      end
    end
    bias = BW'(bv);
  endtask

  // Offer the current beat until accepted; returns the acceptance cycle.
  task automatic push_beat(output int acc_cyc);
    bit ok;
    ok      = 0;
    acc_cyc = -1;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok      = 1;
        acc_cyc = cyc;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic run_group(input int dv, input int wv, input int bv, input bit hi7,
                           output int last_cyc);
    int c;
    last_cyc = -1;
    for (int b = 0; b < BEATS; b++) begin
      set_beat(dv, wv, bv, hi7, b);
      push_beat(c);
      last_cyc = c;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int at);
    bit seen;
    seen = 0;
    at   = -1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        at   = cyc;
      end
    end
    if (!seen) check("out_timeout", 0, 1);
  endtask

  task automatic drain_check(input string name);
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check({name, "_result"}, got_q[i], exp_q[i]);
    end
    got_q.delete();
    got_cyc_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int last_c;
    int out_c;

    tbl[0] = '{dv:  1, wv:  1, bv:    0, hi7: 0, exp_relu:  31, exp_pass:   31};
    tbl[1] = '{dv:  1, wv: -1, bv:    0, hi7: 0, exp_relu:   0, exp_pass:  -32};
    tbl[2] = '{dv:  7, wv:  7, bv:    0, hi7: 0, exp_relu: 127, exp_pass:  127};
    tbl[3] = '{dv:  1, wv:  1, bv:    0, hi7: 1, exp_relu:  31, exp_pass:   31};
    tbl[4] = '{dv:  1, wv:  1, bv: -126, hi7: 0, exp_relu:   0, exp_pass:    0};
    tbl[5] = '{dv:  1, wv:  1, bv:  127, hi7: 0, exp_relu:  63, exp_pass:   63};
    tbl[6] = '{dv: -8, wv: -8, bv:    0, hi7: 0, exp_relu: 127, exp_pass:  127};
    tbl[7] = '{dv: -8, wv:  7, bv:    0, hi7: 0, exp_relu:   0, exp_pass: -128};
    tbl[8] = '{dv:  1, wv:  1, bv: -128, hi7: 0, exp_relu:   0, exp_pass:   -1};
    tbl[9] = '{dv:  2, wv:  1, bv:   -1, hi7: 0, exp_relu:  62, exp_pass:   62};

    rst       = 1'b1;
    in_valid  = 1'b0;
    data      = '0;
    w         = '0;
    bias      = '0;
    out_ready = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_d_out", int'(d_out), 0);
    check("rst_in_ready", int'(in_ready), 1);
    rst      = 1'b1;
    sb_watch = 1;
    @(posedge clk);
    #1;

    // Directed vectors, one group each, no stall.
    foreach (tbl[i]) begin
      run_group(tbl[i].dv, tbl[i].wv, tbl[i].bv, tbl[i].hi7, last_c);
      wait_out(out_c);
      check("tbl_latency", out_c - last_c, 3);
      check("tbl_d_out", int'($signed(d_out)), tbl[i].exp_relu);
      check("tbl_d_out_norelu", int'($signed(d_out_nr)), tbl[i].exp_pass);
      check("tbl_valid_norelu", int'(out_valid_nr), 1);
      @(posedge clk);
      #1;
      drain_check("tbl");
    end

    // Backpressure: two groups stream while the first result is held 5 cycles.
    out_ready = 1'b0;
    fork
      begin
        int c;
        for (int g = 0; g < 2; g++) begin
          for (int b = 0; b < BEATS; b++) begin
            set_beat(1, 1, 0, 0, b);
            push_beat(c);
          end
        end
        in_valid = 1'b0;
      end
      begin
        bit seen;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
          @(negedge clk);
          if (out_valid) seen = 1;
        end
        check("bp_seen", int'(seen), 1);
        for (int s = 0; s < 5; s++) begin
          if (s > 0) @(negedge clk);
          check("bp_in_ready", int'(in_ready), 0);
          check("bp_valid", int'(out_valid), 1);
          check("bp_d_out", int'($signed(d_out)), 31);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1;
    check("bp_count", got_q.size(), 2);
    foreach (got_q[i]) check("bp_result", got_q[i], 31);
    drain_check("bp");

    // Back-to-back groups: one result every BEATS cycles.
    for (int g = 0; g < 3; g++) run_group(1, 1, 0, 0, last_c);
    repeat (8) @(posedge clk);
    #1;
    check("tp_count", got_q.size(), 3);
    for (int i = 1; i < got_cyc_q.size(); i++) begin
      check("tp_interval", got_cyc_q[i] - got_cyc_q[i-1], BEATS);
    end
    drain_check("tp");

    // Reset in the middle of a group discards it.
    for (int b = 0; b < 3; b++) begin
      set_beat(1, 1, 0, 0, b);
      push_beat(last_c);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_d_out", int'(d_out), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1;
    got_q.delete();
    got_cyc_q.delete();
    exp_q.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_group(1, 1, 0, 0, last_c);
    wait_out(out_c);
    check("post_rst_latency", out_c - last_c, 3);
    check("post_rst_d_out", int'($signed(d_out)), 31);
    @(posedge clk);
    #1;
    drain_check("post_rst");

    // Random traffic with random bubbles and backpressure.
    for (int t = 0; t < 600; t++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < LANES * KK; i++) begin
        data[i*N +: N] = N'($urandom);
        w[i*M +: M]    = M'($urandom);
      end
      bias = BW'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("rand_nonempty", int'(got_q.size() > 10), 1);
    drain_check("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ce_fold.md
CE_FOLD -- requirements
Module: ce_fold

Interface
REQ-001 Parameter CL_IN, default 14: number of input channels (feature maps) per output pixel.
REQ-002 Parameter KERNEL, default 3: kernel side; legal values 1/3/5/7.
REQ-003 Parameter LANES, default 4: channels processed per input beat, with 1 <= LANES <= CL_IN.
REQ-004 Parameter N, default 4: data width, signed two's complement.
REQ-005 Parameter M, default 4: weight width, signed two's complement.
REQ-006 Parameter SR, default 2: arithmetic right shift applied before output.
REQ-007 Parameter RELU, default 1: 1 clamps negative results to 0; 0 passes them through.
REQ-008 Parameter OW, default 8: output width, signed.
REQ-009 clk  in  1  single clock; all state changes on the rising edge.
REQ-010 rst  in  1  asynchronous, active-low reset.
REQ-011 in_valid  in  1  a beat is offered.
REQ-012 in_ready  out  1  the beat is accepted when in_valid && in_ready.
REQ-013 data  in  LANES*KERNEL*KERNEL*N  LANES channel windows; lane l occupies bits [l*K*K*N +: K*K*N].
REQ-014 w  in  LANES*KERNEL*KERNEL*M  weights, same packing as data.
REQ-015 bias  in  N+M  signed bias, sampled on the first beat of a group.
REQ-016 out_valid  out  1  result available.
REQ-017 out_ready  in  1  the result is consumed when out_valid && out_ready.
REQ-018 d_out  out  OW  result.

Function
REQ-019 BEATS = ceil(CL_IN/LANES); each output is computed from one group of BEATS accepted beats.
REQ-020 An internal beat counter runs 0..BEATS-1 and wraps to 0 after the last beat; there is no in_last port.
REQ-021 On the last beat, lanes with channel index (beat*LANES + l) >= CL_IN are forced to zero regardless of the data and w inputs.
REQ-022 Product width is N+M; ACCW = N+M+clog2(CL_IN*KERNEL*KERNEL)+1; all sums are computed at ACCW with no internal overflow.
REQ-023 Pipeline:
- S1 registers the products.
- S2 registers the lane adder-tree sum.
- S3 performs the accumulate.
- On the group's final beat, S3 also loads the output register with post-processing applied.
REQ-024 The accumulator is loaded with (sign-extended bias + beat sum) on beat 0 and adds the beat sum on later beats.
REQ-025 Post-processing order:
- arithmetic shift right by SR (floor);
- ReLU per the RELU parameter;
- saturate to the signed OW range.
REQ-026 Latency: the last beat accepted at cycle t gives out_valid=1 at t+3 when no stall occurs.
REQ-027 A global enable is defined as en = !(out_valid && !out_ready); all pipeline stages and the beat counter advance only when en=1.
REQ-028 in_ready = en.
REQ-029 While out_valid=1 and out_ready=0, d_out and out_valid hold stable.
REQ-030 Bubbles (in_valid=0) move through the pipeline without touching the accumulator or the counter.
REQ-031 When the result is consumed and a new final beat completes in the same cycle, out_valid stays 1 and d_out updates; no result is lost or duplicated.
REQ-032 Sustained throughput is one result per BEATS cycles.
REQ-033 When BEATS=1, every accepted beat produces a result.

Reset
REQ-034 Reset clears to zero: beat counter, pipeline valid bits, accumulator, out_valid, and d_out.
REQ-035 A reset asserted mid-group discards the partial group; the first beat after reset release is beat 0.
REQ-036 in_ready is 1 out of reset.

Structure
REQ-037 Package ce_pkg holds the clog2 function and the width and BEATS derivations shared with CE.
REQ-038 Sub-module ce_mac_tree performs the LANES*K*K multiplies and the registered adder tree (S1-S2) for one beat.
REQ-039 The remaining logic (counter, lane mask, accumulator, post-processing, handshake) lives in ce_fold.

Verification (defaults: CL_IN=14, K=3, LANES=4, N=M=4, SR=2, OW=8, so BEATS=4)
REQ-040 All data=1, w=1, bias=0 -> sum 126 -> d_out=31, with out_valid 3 cycles after the fourth beat.
REQ-041 data=1, w=-1 (4'hF) -> with RELU=1, d_out=0; with RELU=0, d_out=-32.
REQ-042 data=7, w=7 -> sum 6174 >>2 = 1543 -> d_out=127 (saturated).
REQ-043 Same stimulus as REQ-040 but lanes 2-3 of beat 3 driven with 7s -> d_out=31 (masking).
REQ-044 Backpressure case:
- out_ready held low 5 cycles while beats stream -> in_ready=0, d_out stable;
- then out_ready=1 -> consecutive results 31, 31 with no loss;
- back-to-back groups give one out_valid per 4 cycles.
REQ-045 rst pulsed low after beat 2 -> all outputs 0; a following full group -> d_out=31.
